// File: rtl/mips_pkg.sv
// Shared MIPS constants, fetch FSM state encoding and the branch-offset helper.
package mips_pkg;

    // Opcode / funct fields used by the fetch-side control flow
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // sll $0,$0,0 encodes as all zeros and is the canonical bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // BOOT is a one-cycle settle state after reset release with no cache read
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2
    } fetch_state_t;

    // Sign-extend a 16-bit word offset and convert it to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Combinational next-PC helper: sequential PC+4 and the JR > Jump > Branch
// redirect target computed from the instruction currently held in IF/ID.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    input  logic [31:0] rs_data,
    input  logic        jr,
    input  logic        jump,
    output logic [31:0] pc_plus4,
    output logic [31:0] redirect_tgt
);

    // Sequential successor; 32-bit wrap at the top of the address space is intended
    assign pc_plus4 = pc + 32'd4;

    // Target mux; JR targets are forced word aligned
    always_comb begin
        redirect_tgt = pc4 + branch_offset(instr[15:0]);
        if (jr) begin
            redirect_tgt = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            redirect_tgt = {pc4[31:28], instr[25:0], 2'b00};
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, I-cache request, pending redirect and the
// IF/ID pipeline register. Defining IFETCH_PERF_CNT_EN adds saturating
// fetch/stall performance counters; otherwise the perf ports read zero.
//
// Handshake: the I-cache read is a single-cycle request. oICACHE_ren/addr are
// driven from registered state; iICACHE_rdata is consumed in the same cycle
// only when ren=1 and iICACHE_stall=0. A stall freezes the whole stage.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             oICACHE_ren,
    output logic [29:0]      oICACHE_addr,
    input  logic [31:0]      iICACHE_rdata,
    input  logic             iICACHE_stall,
    input  logic             iHazard_stall,
    input  logic             iJump,
    input  logic             iJR,
    input  logic             iBranch,
    input  logic             iEqual,
    input  logic [31:0]      iRS_data,
    output logic [31:0]      oIFID_instr,
    output logic [31:0]      oIFID_pc4,
    output logic             oIFID_valid,
    output logic [CNT_W-1:0] oPerf_fetch,
    output logic [CNT_W-1:0] oPerf_stall,
    output logic [1:0]       dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic         pend_valid_q;
    logic [31:0]  pend_tgt_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_tgt;
    logic         redirect;
    logic         fetch_accept;

    next_pc_sel u_next_pc_sel (
        .pc           (pc_q),
        .instr        (oIFID_instr),
        .pc4          (oIFID_pc4),
        .rs_data      (iRS_data),
        .jr           (iJR),
        .jump         (iJump),
        .pc_plus4     (pc_plus4),
        .redirect_tgt (redirect_tgt)
    );

    // A control transfer is only honoured for a real instruction not held by a load-use stall
    assign redirect = ~iHazard_stall & (iJR | iJump | (iBranch & iEqual)) & oIFID_valid;

    // Cycle in which a fetched instruction actually enters IF/ID
    assign fetch_accept = (state_q != BOOT) & ~iICACHE_stall & ~redirect
                        & ~pend_valid_q & ~iHazard_stall;

    assign oICACHE_addr = pc_q[31:2];
    assign dbg_state    = state_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and cache read enable
    always_comb begin
        state_d     = state_q;
        oICACHE_ren = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                oICACHE_ren = 1'b1;
                if (iICACHE_stall) state_d = MISS;
            end
            MISS: begin
                oICACHE_ren = 1'b1;
                if (!iICACHE_stall) state_d = FETCH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC, pending redirect and IF/ID update; first matching rule wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            oIFID_instr  <= NOP_INSTR;
            oIFID_pc4    <= '0;
            oIFID_valid  <= 1'b0;
        end else if (state_q == BOOT) begin
            // No read is issued in BOOT, so nothing advances
        end else if (iICACHE_stall) begin
            // Keep the first redirect seen during a miss; IF/ID holds so it may repeat
            if (redirect && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_tgt_q   <= redirect_tgt;
            end
        end else if (redirect || pend_valid_q) begin
            pc_q         <= pend_valid_q ? pend_tgt_q : redirect_tgt;
            pend_valid_q <= 1'b0;
            oIFID_instr  <= NOP_INSTR;
            oIFID_pc4    <= '0;
            oIFID_valid  <= 1'b0;
        end else if (iHazard_stall) begin
            // Load-use stall: hold PC and IF/ID
        end else begin
            pc_q        <= pc_plus4;
            oIFID_instr <= iICACHE_rdata;
            oIFID_pc4   <= pc_plus4;
            oIFID_valid <= 1'b1;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating counters of accepted fetches and I-cache stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_accept && (fetch_cnt_q != {CNT_W{1'b1}})) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
            if (iICACHE_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign oPerf_fetch = fetch_cnt_q;
    assign oPerf_stall = stall_cnt_q;
`else
    assign oPerf_fetch = '0;
    assign oPerf_stall = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, jump, taken/not-taken beq,
// JR under I-cache miss, load-use hold and asynchronous reset mid-miss.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren;
    logic [29:0] addr;
    logic [31:0] rdata;
    logic        icache_stall;
    logic        hazard_stall;
    logic        jump;
    logic        jr;
    logic        branch;
    logic        equal;
    logic [31:0] rs_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .oICACHE_ren   (ren),
        .oICACHE_addr  (addr),
        .iICACHE_rdata (rdata),
        .iICACHE_stall (icache_stall),
        .iHazard_stall (hazard_stall),
        .iJump         (jump),
        .iJR           (jr),
        .iBranch       (branch),
        .iEqual        (equal),
        .iRS_data      (rs_data),
        .oIFID_instr   (ifid_instr),
        .oIFID_pc4     (ifid_pc4),
        .oIFID_valid   (ifid_valid),
        .oPerf_fetch   (perf_fetch),
        .oPerf_stall   (perf_stall),
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                              input logic v);
        check({tag, "_instr"}, ifid_instr, ins);
        check({tag, "_pc4"}, ifid_pc4, p4);
        check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    endtask

    logic [31:0] i_a, i_b, i_c, i_j1, i_j2, i_beq, i_jr, i_j3, i_e, i_f, i_h, i_t, junk;

    initial begin
        i_a   = 32'h2001_0001;
        i_b   = 32'h2002_0002;
        i_c   = 32'h2003_0003;
        i_j1  = {OP_J, 26'h000_0010};                 // target 0x40
        i_j2  = {OP_J, 26'h000_0007};                 // target 0x1C
        i_beq = {OP_BEQ, 5'd1, 5'd2, 16'hFFFF};        // offset -4
        i_jr  = {OP_RTYPE, 5'd3, 15'd0, FUNCT_JR};
        i_j3  = {OP_J, 26'h000_0020};                 // target 0x80
        i_e   = 32'h2004_0004;
        i_f   = 32'h2005_0005;
        i_h   = 32'h2006_0006;
        i_t   = 32'h2007_0007;
        junk  = 32'hDEAD_BEEF;

        rst_n = 1'b0; rdata = '0; icache_stall = 0; hazard_stall = 0;
        jump = 0; jr = 0; branch = 0; equal = 0; rs_data = '0;

        // Reset values
        #12;
        check("rst_ren", {31'd0, ren}, 32'd0);
        check("rst_addr", {2'b0, addr}, 32'd0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, BOOT});
        check("rst_pfetch", perf_fetch, 32'd0);
        check("rst_pstall", perf_stall, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        check("boot_state", {30'd0, dbg_state}, {30'd0, BOOT});
        check("boot_ren", {31'd0, ren}, 32'd0);
        step();
        check("fetch_state", {30'd0, dbg_state}, {30'd0, FETCH});
        check("fetch_ren", {31'd0, ren}, 32'd1);
        check("addr0", {2'b0, addr}, 32'd0);

        // Three sequential hits
        rdata = i_a; step();
        check_ifid("hitA", i_a, 32'd4, 1'b1);
        check("addr1", {2'b0, addr}, 32'd1);
        rdata = i_b; step();
        check_ifid("hitB", i_b, 32'd8, 1'b1);
        check("addr2", {2'b0, addr}, 32'd2);
        rdata = i_c; step();
        check_ifid("hitC", i_c, 32'd12, 1'b1);

        // Jump to 0x40: one bubble then the target instruction
        rdata = i_j1; step();
        check_ifid("j1", i_j1, 32'd16, 1'b1);
        jump = 1; rdata = junk; step();
        check("j1_addr", {2'b0, addr}, 32'h10);
        check_ifid("j1_bubble", 32'h0, 32'h0, 1'b0);
        jump = 0; rdata = i_t; step();
        check_ifid("j1_tgt", i_t, 32'h44, 1'b1);

        // Jump to 0x1C to place beq at pc4=0x20
        rdata = i_j2; step();
        jump = 1; rdata = junk; step();
        check("j2_addr", {2'b0, addr}, 32'h7);
        jump = 0; rdata = i_beq; step();
        check_ifid("beq1", i_beq, 32'h20, 1'b1);

        // Taken beq, offset -1 word: PC = 0x20 - 4 = 0x1C
        branch = 1; equal = 1; rdata = junk; step();
        check("beq_taken_addr", {2'b0, addr}, 32'h7);
        check_ifid("beq_bubble", 32'h0, 32'h0, 1'b0);
        branch = 0; equal = 0; rdata = i_beq; step();
        check_ifid("beq2", i_beq, 32'h20, 1'b1);

        // Not-taken beq: sequential fetch continues at 0x24
        branch = 1; equal = 0; rdata = i_e; step();
        check_ifid("beq_nt", i_e, 32'h24, 1'b1);
        check("beq_nt_addr", {2'b0, addr}, 32'h9);
        branch = 0;

        // JR during a 4-cycle miss, misaligned target 0x103 -> 0x100
        rdata = i_jr; step();
        check_ifid("jr", i_jr, 32'h28, 1'b1);
        jr = 1; rs_data = 32'h0000_0103; icache_stall = 1; rdata = junk;
        for (int k = 0; k < 4; k++) begin
            step();
            check("jr_miss_addr", {2'b0, addr}, 32'hA);
            check("jr_miss_valid", {31'd0, ifid_valid}, 32'd1);
        end
        check("miss_state", {30'd0, dbg_state}, {30'd0, MISS});
        icache_stall = 0; step();
        check("jr_addr", {2'b0, addr}, 32'h40);
        check_ifid("jr_bubble", 32'h0, 32'h0, 1'b0);
        jr = 0; rdata = i_f; step();
        check_ifid("jr_tgt", i_f, 32'h104, 1'b1);

        // Load-use stall suppresses a jump until it releases
        rdata = i_j3; step();
        check_ifid("j3", i_j3, 32'h108, 1'b1);
        jump = 1; hazard_stall = 1; rdata = junk;
        step();
        check("haz_addr1", {2'b0, addr}, 32'h42);
        check_ifid("haz1", i_j3, 32'h108, 1'b1);
        step();
        check("haz_addr2", {2'b0, addr}, 32'h42);
        hazard_stall = 0; step();
        check("haz_rel_addr", {2'b0, addr}, 32'h20);
        check_ifid("haz_bubble", 32'h0, 32'h0, 1'b0);
        jump = 0;

        // Enter a miss, then reset asynchronously in the middle of it
        rdata = i_h; step();
        check_ifid("h", i_h, 32'h84, 1'b1);
        icache_stall = 1; step();
`ifdef IFETCH_PERF_CNT_EN
        check("pfetch_cnt", perf_fetch, 32'd13);
        check("pstall_cnt", perf_stall, 32'd5);
`else
        check("pfetch_off", perf_fetch, 32'd0);
        check("pstall_off", perf_stall, 32'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ren", {31'd0, ren}, 32'd0);
        check("arst_addr", {2'b0, addr}, 32'd0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        check("arst_pfetch", perf_fetch, 32'd0);
        check("arst_pstall", perf_stall, 32'd0);
        icache_stall = 0;
        step();
        rst_n = 1'b1;
        check("arst_boot_ren", {31'd0, ren}, 32'd0);
        step();
        check("arst_fetch_ren", {31'd0, ren}, 32'd1);
        check("arst_fetch_addr", {2'b0, addr}, 32'd0);
        rdata = i_a; step();
        check_ifid("arst_hitA", i_a, 32'd4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
